// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART RX frame controller
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - serial line, counter/sampler and frame output bundle (err_count with UART_RX_ERR_CNT_EN)
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int ERR_CNT_W  = 8
) ();

    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic [4:0]            edge_count;
    logic [3:0]            bit_count;
    logic                  sampled_bit;
    logic                  counter_enable;
    logic                  data_samp_en;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]  err_count;

    modport master (
        input  rx_in, prescale, par_en, par_typ, edge_count, bit_count, sampled_bit,
        output counter_enable, data_samp_en, p_data, data_valid, par_err, stp_err, busy, err_count
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, edge_count, bit_count, sampled_bit,
        input  counter_enable, data_samp_en, p_data, data_valid, par_err, stp_err, busy, err_count
    );
`else
    modport master (
        input  rx_in, prescale, par_en, par_typ, edge_count, bit_count, sampled_bit,
        output counter_enable, data_samp_en, p_data, data_valid, par_err, stp_err, busy
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, edge_count, bit_count, sampled_bit,
        input  counter_enable, data_samp_en, p_data, data_valid, par_err, stp_err, busy
    );
`endif

endinterface

// File: rtl/uart_rx_parity_calc.sv
// rtl/uart_rx_parity_calc.sv - expected parity bit for a received data word
module uart_rx_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    always_comb begin
        par_bit = ^data;
        case (par_typ)
            PAR_EVEN: par_bit = ^data;
            PAR_ODD:  par_bit = ~^data;
            default:  par_bit = ^data;
        endcase
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX frame controller: start/parity/stop checks, LSB-first deserialiser
// Optional saturating frame-error counter enabled by UART_RX_ERR_CNT_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int ERR_CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.master bus
);

    state_t                state;
    state_t                state_nxt;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic [4:0]            sp;
    logic [4:0]            ep;
    logic                  at_sp;
    logic                  at_ep;
    logic                  presc_ok;
    logic                  par_exp;
    logic                  frame_start;

    // Sample/end points come from the prescale latched at frame start, not the live input.
    assign sp    = 5'(presc_q >> 1) + 5'd1;
    assign ep    = 5'(presc_q - 1'b1);
    assign at_sp = (bus.edge_count == sp);
    assign at_ep = (bus.edge_count == ep);

    assign presc_ok = (bus.prescale == PRESCALE_W'(PRESC_8))  ||
                      (bus.prescale == PRESCALE_W'(PRESC_16)) ||
                      (bus.prescale == PRESCALE_W'(PRESC_32));

    assign frame_start = (state == IDLE) && (state_nxt == START);

    uart_rx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data    (shift_reg),
        .par_typ (par_typ_q),
        .par_bit (par_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.rx_in && presc_ok) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (at_sp && bus.sampled_bit) begin
                    state_nxt = IDLE;
                end else if (at_ep) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_ep && (bus.bit_count == 4'(DATA_WIDTH))) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_ep) begin
                    state_nxt = STOP;
                end
            end
            // Leave at the stop sample point so an immediately following start edge is seen.
            STOP: begin
                if (at_sp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_reg    <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            if (frame_start) begin
                presc_q   <= bus.prescale;
                par_en_q  <= bus.par_en;
                par_typ_q <= bus.par_typ;
                par_err_q <= 1'b0;
                stp_err_q <= 1'b0;
            end
            case (state)
                DATA: begin
                    if (at_sp) begin
                        shift_reg <= {bus.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    end
                end
                PARITY: begin
                    if (at_sp && (bus.sampled_bit != par_exp)) begin
                        par_err_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (at_sp) begin
                        if (!bus.sampled_bit) begin
                            stp_err_q <= 1'b1;
                        end
                        if (!par_err_q && bus.sampled_bit) begin
                            p_data_q     <= shift_reg;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if ((state == STOP) && at_sp && (par_err_q || !bus.sampled_bit) &&
                     (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

    assign bus.counter_enable = (state != IDLE);
    assign bus.data_samp_en   = (state != IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.p_data         = p_data_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.par_err        = par_err_q;
    assign bus.stp_err        = stp_err_q;

endmodule
